// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@74Hz raster constants, phase type and phase decode helper
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 64;
  localparam int DEF_H_BP = 120;
  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 1;
  localparam int DEF_V_SYNC = 3;
  localparam int DEF_V_BP = 16;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_CW = 11;
  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_e;
  function automatic phase_e axis_phase(input int c, input int active, input int fp, input int sync);
    return c < active ? PH_ACTIVE : c < active + fp ? PH_FRONT : c < active + fp + sync ? PH_SYNC : PH_BACK;
  endfunction
endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter: one raster axis; wrapping counter with sync-phase decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = DEF_H_TOTAL,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] nxt,
  output logic          sync_on
);
  logic [CW-1:0] cnt_q, cnt_d;
  phase_e phase;
  // advance when enabled, wrapping TOTAL-1 back to 0
  always_comb begin
    cnt_d = (en && cnt_q == CW'(TOTAL - 1)) ? '0 : cnt_q + CW'(en);
    phase = axis_phase(int'(cnt_q), ACTIVE, FP, SYNC);
  end
  // count register; reset parks on the last position so the first edge lands on 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= CW'(TOTAL - 1);
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign nxt = cnt_d;
  assign sync_on = phase == PH_SYNC;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster request generator with latency-matched sync/de/rgb output stage
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP = DEF_H_FP,
  parameter int   H_SYNC = DEF_H_SYNC,
  parameter int   H_BP = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP = DEF_V_FP,
  parameter int   V_SYNC = DEF_V_SYNC,
  parameter int   V_BP = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIX_LAT = 2,
  parameter int   RGB_W = 4,
  parameter int   CW = DEF_CW
) (
  input  logic             clki,
  input  logic             resetn,
  output logic [CW-1:0]    req_x,
  output logic [CW-1:0]    req_y,
  output logic             req_valid,
  output logic             frame_start,
  output logic             line_start,
  input  logic [3*RGB_W-1:0] rgb_in,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [3*RGB_W-1:0] vga_rgb
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [CW-1:0] h_nxt, v_nxt;
  logic h_sync_on, v_sync_on, h_wrap;
  logic req_valid_q, req_valid_d, frame_start_q, frame_start_d, line_start_q, line_start_d;
  logic [PIX_LAT-1:0] hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d, vga_de_q, vga_de_d;
  logic [3*RGB_W-1:0] vga_rgb_q, vga_rgb_d;
  assign h_wrap = req_x == CW'(H_TOTAL - 1);
  vga_axis_counter #(.TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .CW(CW)) u_h (
    .clk(clki), .rst_n(resetn), .en(1'b1), .cnt(req_x), .nxt(h_nxt), .sync_on(h_sync_on)
  );
  vga_axis_counter #(.TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .CW(CW)) u_v (
    .clk(clki), .rst_n(resetn), .en(h_wrap), .cnt(req_y), .nxt(v_nxt), .sync_on(v_sync_on)
  );
  // request flags follow the next counts so they line up with the counters; syncs and
  // valid of the current request enter the delay line that absorbs renderer latency
  always_comb begin
    req_valid_d = h_nxt < CW'(H_ACTIVE) && v_nxt < CW'(V_ACTIVE);
    frame_start_d = h_nxt == '0 && v_nxt == '0;
    line_start_d = h_nxt == '0;
    hs_d[0] = h_sync_on ? SYNC_POL : ~SYNC_POL;
    vs_d[0] = v_sync_on ? SYNC_POL : ~SYNC_POL;
    de_d[0] = req_valid_q;
    for (int i = 1; i < PIX_LAT; i++) begin
      hs_d[i] = hs_q[i-1];
      vs_d[i] = vs_q[i-1];
      de_d[i] = de_q[i-1];
    end
    vga_hs_d = hs_q[PIX_LAT-1];
    vga_vs_d = vs_q[PIX_LAT-1];
    vga_de_d = de_q[PIX_LAT-1];
    vga_rgb_d = de_q[PIX_LAT-1] ? rgb_in : '0;
  end
  // request flags, delay line and pin registers; reset returns everything to idle
  always_ff @(posedge clki or negedge resetn)
    if (!resetn) begin
      req_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q <= 1'b0;
      hs_q <= {PIX_LAT{~SYNC_POL}};
      vs_q <= {PIX_LAT{~SYNC_POL}};
      de_q <= '0;
      vga_hs_q <= ~SYNC_POL;
      vga_vs_q <= ~SYNC_POL;
      vga_de_q <= 1'b0;
      vga_rgb_q <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      frame_start_q <= frame_start_d;
      line_start_q <= line_start_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      vga_hs_q <= vga_hs_d;
      vga_vs_q <= vga_vs_d;
      vga_de_q <= vga_de_d;
      vga_rgb_q <= vga_rgb_d;
    end
  assign req_valid = req_valid_q;
  assign frame_start = frame_start_q;
  assign line_start = line_start_q;
  assign vga_hs = vga_hs_q;
  assign vga_vs = vga_vs_q;
  assign vga_de = vga_de_q;
  assign vga_rgb = vga_rgb_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing and shrunk-timing instances checked against cycle-index expectations
module tb_vga_timing_gen;
  logic clki = 1'b0;
  logic resetn = 1'b0;
  always #5 clki = ~clki;

  logic [10:0] a_req_x, a_req_y, b_req_x, b_req_y;
  logic a_req_valid, a_frame_start, a_line_start, a_vga_hs, a_vga_vs, a_vga_de;
  logic b_req_valid, b_frame_start, b_line_start, b_vga_hs, b_vga_vs, b_vga_de;
  logic [11:0] a_rgb_in, a_vga_rgb, b_vga_rgb, ra1, ra2;
  logic [11:0] b_rgb_in = 12'hFFF;

  vga_timing_gen u_a (
    .clki(clki), .resetn(resetn), .req_x(a_req_x), .req_y(a_req_y), .req_valid(a_req_valid),
    .frame_start(a_frame_start), .line_start(a_line_start), .rgb_in(a_rgb_in),
    .vga_hs(a_vga_hs), .vga_vs(a_vga_vs), .vga_de(a_vga_de), .vga_rgb(a_vga_rgb)
  );
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(6), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) u_b (
    .clki(clki), .resetn(resetn), .req_x(b_req_x), .req_y(b_req_y), .req_valid(b_req_valid),
    .frame_start(b_frame_start), .line_start(b_line_start), .rgb_in(b_rgb_in),
    .vga_hs(b_vga_hs), .vga_vs(b_vga_vs), .vga_de(b_vga_de), .vga_rgb(b_vga_rgb)
  );

  // renderer for the default instance: echoes a coordinate tag two cycles after the request
  always @(posedge clki or negedge resetn)
    if (!resetn) begin
      ra1 <= 12'h0;
      ra2 <= 12'h0;
    end else begin
      ra1 <= {a_req_x[3:0], a_req_y[3:0], 4'h5};
      ra2 <= ra1;
    end
  assign a_rgb_in = ra2;

  wire [39:0] a_vec = {a_req_x, a_req_y, a_req_valid, a_frame_start, a_line_start, a_vga_hs, a_vga_vs, a_vga_de, a_vga_rgb};
  wire [39:0] b_vec = {b_req_x, b_req_y, b_req_valid, b_frame_start, b_line_start, b_vga_hs, b_vga_vs, b_vga_de, b_vga_rgb};

  int checks = 0;
  int errors = 0;
  int a_hs_low, a_hs_first, a_de_first, a_ls_first, a_ls_second;
  int b_fs_first, b_fs_second, b_vs_low, b_vs_first, b_de_cnt, b_fff_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // expected outputs after the k-th clock edge since reset release
  function automatic logic [39:0] expect_vec(input int k, input int ha, input int hf, input int hs, input int hb,
                                             input int va, input int vf, input int vs, input int vb, input bit coord);
    int ht, vt, p, x, y, q, qx, qy;
    logic rv, fs, ls, ho, vo, de;
    logic [11:0] rgb;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p = k - 1;
    x = p % ht;
    y = (p / ht) % vt;
    rv = x < ha && y < va;
    fs = x == 0 && y == 0;
    ls = x == 0;
    q = k - 4;
    if (q < 0) begin
      ho = 1'b1;
      vo = 1'b1;
      de = 1'b0;
      rgb = 12'h0;
    end else begin
      qx = q % ht;
      qy = (q / ht) % vt;
      de = qx < ha && qy < va;
      ho = !(qx >= ha + hf && qx < ha + hf + hs);
      vo = !(qy >= va + vf && qy < va + vf + vs);
      rgb = !de ? 12'h0 : coord ? {qx[3:0], qy[3:0], 4'h5} : 12'hFFF;
    end
    return {11'(x), 11'(y), rv, fs, ls, ho, vo, de, rgb};
  endfunction

  function automatic logic [39:0] rst_vec(input int ht, input int vt);
    return {11'(ht - 1), 11'(vt - 1), 3'b000, 3'b110, 12'h0};
  endfunction

  task automatic run(input int n, input bit measure);
    for (int k = 1; k <= n; k++) begin
      @(negedge clki);
      check($sformatf("a_cyc%0d", k), 64'(a_vec), 64'(expect_vec(k, 640, 16, 64, 120, 480, 1, 3, 16, 1'b1)));
      check($sformatf("b_cyc%0d", k), 64'(b_vec), 64'(expect_vec(k, 16, 2, 4, 6, 6, 1, 2, 3, 1'b0)));
      if (measure) begin
        if (k <= 840 && !a_vga_hs) a_hs_low++;
        if (a_hs_first < 0 && !a_vga_hs) a_hs_first = k;
        if (a_de_first < 0 && a_vga_de) a_de_first = k;
        if (a_line_start) begin
          if (a_ls_first < 0) a_ls_first = k;
          else if (a_ls_second < 0) a_ls_second = k;
        end
        if (b_frame_start) begin
          if (b_fs_first < 0) b_fs_first = k;
          else if (b_fs_second < 0) b_fs_second = k;
        end
        if (k <= 336 && !b_vga_vs) b_vs_low++;
        if (b_vs_first < 0 && !b_vga_vs) b_vs_first = k;
        if (k <= 336 && b_vga_de) b_de_cnt++;
        if (k <= 336 && b_vga_rgb == 12'hFFF) b_fff_cnt++;
      end
    end
  endtask

  initial begin
    bit found;
    {a_hs_low, b_vs_low, b_de_cnt, b_fff_cnt} = '0;
    {a_hs_first, a_de_first, a_ls_first, a_ls_second} = {4{32'hFFFF_FFFF}};
    {b_fs_first, b_fs_second, b_vs_first} = {3{32'hFFFF_FFFF}};
    repeat (3) @(negedge clki);
    check("reset_a", 64'(a_vec), 64'(rst_vec(840, 500)));
    check("reset_b", 64'(b_vec), 64'(rst_vec(28, 12)));
    resetn = 1'b1;
    run(1780, 1'b1);
    check("a_hs_low_cycles", 64'(a_hs_low), 64'd64);
    check("a_hs_first_low", 64'(a_hs_first), 64'd660);
    check("a_de_first", 64'(a_de_first), 64'd4);
    check("a_line_period", 64'(a_ls_second - a_ls_first), 64'd840);
    check("b_frame_period", 64'(b_fs_second - b_fs_first), 64'd336);
    check("b_vs_low_cycles", 64'(b_vs_low), 64'd56);
    check("b_vs_first_low", 64'(b_vs_first), 64'd200);
    check("b_de_cycles", 64'(b_de_cnt), 64'd96);
    check("b_rgb_white_cycles", 64'(b_fff_cnt), 64'd96);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clki);
      if (b_req_x == 11'd10 && b_req_y == 11'd3) found = 1'b1;
    end
    check("mid_wait", 64'(found), 64'd1);
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_a", 64'(a_vec), 64'(rst_vec(840, 500)));
    check("mid_rst_b", 64'(b_vec), 64'(rst_vec(28, 12)));
    repeat (2) @(negedge clki);
    check("held_rst_b", 64'(b_vec), 64'(rst_vec(28, 12)));
    resetn = 1'b1;
    run(400, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator clocked by the 31.25 MHz pixel clock from the PLL; resetn is driven by the PLL lock signal.
- Produces pixel requests (x, y, valid) for the pong renderer one pipeline depth ahead of the display.
- Delays sync and data-enable by the renderer latency, then registers aligned hsync/vsync/de/RGB onto the VGA pins.
- Default timing is 640x480 with 840x500 totals: 31.25e6 / 420000 = 74.4 Hz frame rate.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 64, hsync width (cycles)
- H_BP, 120, horizontal back porch (cycles); H_TOTAL = sum = 840
- V_ACTIVE, 480, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 16, vertical back porch (lines); V_TOTAL = sum = 500
- SYNC_POL, 0, asserted sync level (0 = active-low)
- PIX_LAT, 2, renderer latency in cycles from req to rgb_in (legal 1..8)
- RGB_W, 4, bits per colour channel
- CW, 11, coordinate/counter width (must hold H_TOTAL-1 and V_TOTAL-1)

Ports:
- clki  in  1  pixel clock (PLL output)
- resetn  in  1  asynchronous active-low reset (PLL lock)
- req_x  out  CW  pixel column being requested
- req_y  out  CW  pixel row being requested
- req_valid  out  1  req_x/req_y inside active area
- frame_start  out  1  one-cycle pulse with request (0,0)
- line_start  out  1  one-cycle pulse with every req_x == 0
- rgb_in  in  3*RGB_W  {R,G,B} from renderer, PIX_LAT cycles after matching req
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_de  out  1  display enable
- vga_rgb  out  3*RGB_W  pixel data to pins

Behaviour:
- Reset, asynchronous:
  - hcnt = H_TOTAL-1, vcnt = V_TOTAL-1.
  - All delay-line stages cleared to the idle pattern: sync = ~SYNC_POL, de = 0.
  - Outputs: req_x = H_TOTAL-1, req_y = V_TOTAL-1, req_valid = 0, frame_start = 0, line_start = 0, vga_hs = vga_vs = ~SYNC_POL, vga_de = 0, vga_rgb = 0.
- Counters:
  - hcnt increments each cycle and wraps H_TOTAL-1 -> 0.
  - vcnt increments only on an hcnt wrap and wraps V_TOTAL-1 -> 0.
  - First edge after resetn rises: (0,0) with req_valid = 1, frame_start = 1, line_start = 1.
- Request stage, registered; req_x = hcnt, req_y = vcnt:
  - req_valid = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - frame_start = (hcnt == 0 && vcnt == 0).
  - line_start = (hcnt == 0).
- Phase decode, request domain:
  - hsync asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for whole lines (vsync edges coincide with hcnt == 0).
  - Each axis steps through ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
- Alignment:
  - hsync, vsync and req_valid pass through a PIX_LAT-deep shift register, then one output register.
  - vga_hs/vga_vs/vga_de therefore lag the matching request by PIX_LAT+1 cycles.
  - vga_rgb is registered in the same edge as vga_de: vga_rgb = de_delayed ? rgb_in : 0.
  - rgb_in is sampled exactly PIX_LAT cycles after its request; blanking forces black regardless of rgb_in.
- No back-pressure: the renderer must meet PIX_LAT every cycle.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Restart follows the first-edge rule above. No partial frame is resumed.
- Arithmetic: unsigned, CW bits; phase boundaries compared as constants. No overflow is possible when CW is legal.

Decomposition:
- Package vga_timing_pkg:
  - Default 640x480@74 Hz timing constants and derived H_TOTAL/V_TOTAL.
  - Phase enum {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}.
  - Function returning the phase for a count given (active, fp, sync).
- Sub-module vga_axis_counter (count, wrap, phase, sync decode):
  - Instantiated twice.
  - Horizontal instance: enable = 1.
  - Vertical instance: enable = horizontal wrap.

Test Plan:
- Reset then release -> all outputs at reset values while resetn low; first edge req (0,0), req_valid = 1, frame_start = 1, line_start = 1; vga_de rises 3 cycles later (PIX_LAT = 2).
- Horizontal timing -> req-domain hsync low for hcnt 656..719 (64 cycles); vga_hs low from 3 cycles after req_x = 656; line period 840 cycles.
- Vertical timing -> vga_vs low for exactly 3 lines (2520 cycles) starting line 481; frame_start period 420000 cycles.
- RGB gating -> renderer echoes 12'hFFF always; vga_rgb = 12'hFFF only while vga_de = 1 (640 cycles per line, 480 lines); 0 elsewhere.
- Alignment -> renderer returns {req_x[3:0], req_y[3:0], 4'h5} 2 cycles after req; each vga_rgb matches the coordinate that produced it.
- Reset mid-frame at (300,200) -> outputs return to reset values asynchronously; after release frame restarts at (0,0) with frame_start = 1.
